q_5_27: RTL and testbench

Q_5_27 -- requirements
Module: q_5_27

---
 rtl/q_5_27.sv | 65 ++++++
 tb/tb_q_5_27.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/q_5_27.sv
// Rising-edge detector on x_in built as a 4-state machine (IDLE/ARMED/PULSE/WAIT).
// Define Q_5_27_MEALY_OUT_EN for a same-cycle combinational y_out; the default build uses a registered Moore output.
module q_5_27 (
  input  logic       rstn,
  input  logic       clk,
  input  logic       x_in,
  output logic       y_out,
  output logic [1:0] state,
  output logic [1:0] next_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_PULSE = 2'b10,
    S_WAIT  = 2'b11
  } state_t;

  state_t state_q, state_d;

  // After reset the input must be seen low before any rise can count as an edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = x_in ? S_IDLE  : S_ARMED;
      S_ARMED: state_d = x_in ? S_PULSE : S_ARMED;
      S_PULSE: state_d = x_in ? S_WAIT  : S_ARMED;
      S_WAIT:  state_d = x_in ? S_WAIT  : S_ARMED;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef Q_5_27_MEALY_OUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign y_out = (state_q == S_ARMED) && x_in;
`else
  logic y_q, y_d;

  // y_q mirrors (state_q == PULSE) by loading the decode of the next state.
  assign y_d = (state_d == S_PULSE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  assign y_out = y_q;
`endif

  assign state      = state_q;
  assign next_state = state_d;

endmodule

// File: tb/tb_q_5_27.sv
// Self-checking bench for q_5_27: directed scenarios plus random samples, glitches and resets
// compared against an edge-detection model that tracks "seen low" and "last sample low" flags.
module tb_q_5_27;

  logic       clk;
  logic       rstn;
  logic       x_in;
  logic       y_out;
  logic [1:0] state;
  logic [1:0] next_state;

  int total = 0;
  int bad   = 0;

  // Model: whether a low has been sampled since reset, whether the last sample was low,
  // and whether the last edge was a detected rise.
  bit seenLow  = 1'b0;
  bit prevLow  = 1'b0;
  bit pulseNow = 1'b0;

  q_5_27 dut (
    .rstn       (rstn),
    .clk        (clk),
    .x_in       (x_in),
    .y_out      (y_out),
    .state      (state),
    .next_state (next_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] expState();
    if (!seenLow)      return 2'b00;
    else if (prevLow)  return 2'b01;
    else if (pulseNow) return 2'b10;
    else               return 2'b11;
  endfunction

  function automatic logic [1:0] expNext(input logic xv);
    if (!xv)          return 2'b01;
    else if (prevLow) return 2'b10;
    else if (seenLow) return 2'b11;
    else              return 2'b00;
  endfunction

  function automatic logic [1:0] expY();
`ifdef Q_5_27_MEALY_OUT_EN
    return {1'b0, prevLow & x_in};
`else
    return {1'b0, pulseNow};
`endif
  endfunction

  task automatic modelEdge(input logic xv);
    pulseNow = xv && prevLow;
    if (!xv) begin
      seenLow = 1'b1;
      prevLow = 1'b1;
    end else begin
      prevLow = 1'b0;
    end
  endtask

  task automatic modelReset();
    seenLow  = 1'b0;
    prevLow  = 1'b0;
    pulseNow = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at t=%0t: got=%b expected=%b", tag, $time, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_state"}, state, expState());
    checkOutput({tag, "_y"}, {1'b0, y_out}, expY());
    checkOutput({tag, "_next"}, next_state, expNext(x_in));
  endtask

  task automatic clockEdge(input string tag);
    @(posedge clk);
    modelEdge(x_in);
    #1;
    checkAll({tag, "_post"});
  endtask

  task automatic applyStimulus(input logic xv, input string tag);
    @(negedge clk);
    x_in = xv;
    #1;
    checkAll({tag, "_pre"});
    clockEdge(tag);
  endtask

  // Unsampled glitch: x_in flips and returns well between edges.
  task automatic glitchStimulus(input string tag);
    @(negedge clk);
    #2 x_in = ~x_in;
    #2 x_in = ~x_in;
    clockEdge(tag);
  endtask

  task automatic asyncReset(input string tag);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    modelReset();
    checkAll({tag, "_inrst"});
    #1 rstn = 1'b1;
    clockEdge(tag);
  endtask

  logic [1:0] seqX   [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
  logic [1:0] seqSt  [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b11, 2'b01};

  initial begin
    rstn = 1'b0;
    x_in = 1'b0;
    #1;
    checkAll("reset");
    x_in = 1'b1;
    #1;
    checkOutput("reset_next_x1", next_state, 2'b00);
    x_in = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    clockEdge("release");
    checkOutput("release_state", state, 2'b01);

    // Stay armed, then a rise held high for three edges.
    applyStimulus(1'b0, "armed");
    applyStimulus(1'b1, "rise");
    checkOutput("rise_state", state, 2'b10);
    applyStimulus(1'b1, "hold1");
    checkOutput("hold1_state", state, 2'b11);
    applyStimulus(1'b1, "hold2");
    checkOutput("hold2_y", {1'b0, y_out}, 2'b00);

    // Reset in WAIT with x_in high; must need a low again before re-arming.
    asyncReset("rst_wait");
    checkOutput("rst_wait_state", state, 2'b00);
    applyStimulus(1'b1, "noarm");
    applyStimulus(1'b0, "rearm");
    applyStimulus(1'b1, "rise2");
    asyncReset("rst_pulse");
    applyStimulus(1'b0, "rearm2");

    x_in = 1'b0;
    glitchStimulus("glitch");
    checkOutput("glitch_state", state, 2'b01);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(seqX[i][0], "seq");
      checkOutput("seq_state", state, seqSt[i]);
    end

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)      asyncReset("rnd_rst");
      else if (r < 3)  glitchStimulus("rnd_glitch");
      else             applyStimulus(1'($urandom_range(0, 1)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

endmodule
